// File: rtl/mic1_reg_file.sv
// MIC-1 datapath register file: captures the shifter C bus into any subset of nine registers and feeds the ALU.
// Latency: a write lands on the rising edge and is visible on b_bus and the *_out ports after that edge; no bypass.
// Backpressure: none; every write, memory load and b_sel change is accepted every cycle.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   c_bus, c_wr          C-bus data and per-register write enables {H,OPC,TOS,CPP,LV,SP,PC,MDR,MAR}
//   b_sel, b_bus         B-bus source select and the combinational ALU B operand
//   mem_mdr_ld/_d        memory read data into MDR (wins over a same-cycle C-bus write)
//   mem_mbr_ld/_d        fetched byte into MBR (MBR has no C-bus path)
//   h_out, mar_out, mdr_out, pc_out, mbr_out   register taps
//   mdr_clash            one-cycle registered flag: C-bus and memory both tried to load MDR
module mic1_reg_file #(
  parameter logic [31:0] PC_RST  = 32'h0000_0000,
  parameter logic [31:0] SP_RST  = 32'h0000_8000,
  parameter logic [31:0] LV_RST  = 32'h0000_8000,
  parameter logic [31:0] CPP_RST = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c_bus,
  input  logic [8:0]  c_wr,
  input  logic [3:0]  b_sel,
  input  logic        mem_mdr_ld,
  input  logic [31:0] mem_mdr_d,
  input  logic        mem_mbr_ld,
  input  logic [7:0]  mem_mbr_d,
  output logic [31:0] b_bus,
  output logic [31:0] h_out,
  output logic [31:0] mar_out,
  output logic [31:0] mdr_out,
  output logic [31:0] pc_out,
  output logic [7:0]  mbr_out,
  output logic        mdr_clash
);

  // c_wr bit positions
  localparam int W_MAR = 0;
  localparam int W_MDR = 1;
  localparam int W_PC  = 2;
  localparam int W_SP  = 3;
  localparam int W_LV  = 4;
  localparam int W_CPP = 5;
  localparam int W_TOS = 6;
  localparam int W_OPC = 7;
  localparam int W_H   = 8;

  logic [31:0] mar, mdr, pc, sp, lv, cpp, tos, opc, h;
  logic [7:0]  mbr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar       <= 32'h0;
      mdr       <= 32'h0;
      pc        <= PC_RST;
      sp        <= SP_RST;
      lv        <= LV_RST;
      cpp       <= CPP_RST;
      tos       <= 32'h0;
      opc       <= 32'h0;
      h         <= 32'h0;
      mbr       <= 8'h00;
      mdr_clash <= 1'b0;
    end else begin
      if (c_wr[W_MAR]) mar <= c_bus;
      if (c_wr[W_PC])  pc  <= c_bus;
      if (c_wr[W_SP])  sp  <= c_bus;
      if (c_wr[W_LV])  lv  <= c_bus;
      if (c_wr[W_CPP]) cpp <= c_bus;
      if (c_wr[W_TOS]) tos <= c_bus;
      if (c_wr[W_OPC]) opc <= c_bus;
      if (c_wr[W_H])   h   <= c_bus;

      // Memory read data beats a concurrent C-bus write to MDR; the
      // conflict is flagged for the following cycle only.
      if (mem_mdr_ld)       mdr <= mem_mdr_d;
      else if (c_wr[W_MDR]) mdr <= c_bus;
      mdr_clash <= mem_mdr_ld & c_wr[W_MDR];

      if (mem_mbr_ld) mbr <= mem_mbr_d;
    end
  end

  always_comb begin
    b_bus = 32'h0;
    case (b_sel)
      4'd0:    b_bus = mdr;
      4'd1:    b_bus = pc;
      4'd2:    b_bus = {{24{mbr[7]}}, mbr};  // signed operand byte
      4'd3:    b_bus = {24'h0, mbr};         // unsigned byte / opcode
      4'd4:    b_bus = sp;
      4'd5:    b_bus = lv;
      4'd6:    b_bus = cpp;
      4'd7:    b_bus = tos;
      4'd8:    b_bus = opc;
      default: b_bus = 32'h0;
    endcase
  end

  assign h_out   = h;
  assign mar_out = mar;
  assign mdr_out = mdr;
  assign pc_out  = pc;
  assign mbr_out = mbr;

endmodule

// File: tb/tb_mic1_reg_file.sv
module tb_mic1_reg_file;

  logic        clk;
  logic        rst;
  logic [31:0] c_bus;
  logic [8:0]  c_wr;
  logic [3:0]  b_sel;
  logic        mem_mdr_ld;
  logic [31:0] mem_mdr_d;
  logic        mem_mbr_ld;
  logic [7:0]  mem_mbr_d;
  logic [31:0] b_bus;
  logic [31:0] h_out;
  logic [31:0] mar_out;
  logic [31:0] mdr_out;
  logic [31:0] pc_out;
  logic [7:0]  mbr_out;
  logic        mdr_clash;

  int n_checks;
  int n_fail;

  mic1_reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .c_bus      (c_bus),
    .c_wr       (c_wr),
    .b_sel      (b_sel),
    .mem_mdr_ld (mem_mdr_ld),
    .mem_mdr_d  (mem_mdr_d),
    .mem_mbr_ld (mem_mbr_ld),
    .mem_mbr_d  (mem_mbr_d),
    .b_bus      (b_bus),
    .h_out      (h_out),
    .mar_out    (mar_out),
    .mdr_out    (mdr_out),
    .pc_out     (pc_out),
    .mbr_out    (mbr_out),
    .mdr_clash  (mdr_clash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    c_bus      = 32'h0;
    c_wr       = 9'h000;
    mem_mdr_ld = 1'b0;
    mem_mdr_d  = 32'h0;
    mem_mbr_ld = 1'b0;
    mem_mbr_d  = 8'h00;
  endtask

  // Reset asserted mid-cycle must show up without waiting for a clock edge,
  // and must also swallow writes that are pending at the next edge.
  task automatic test_reset();
    logic [31:0] exp_rst [9];
    exp_rst[0] = 32'h0;     // MDR
    exp_rst[1] = 32'h0;     // PC
    exp_rst[2] = 32'h0;     // MBR signed
    exp_rst[3] = 32'h0;     // MBR unsigned
    exp_rst[4] = 32'h8000;  // SP
    exp_rst[5] = 32'h8000;  // LV
    exp_rst[6] = 32'h4000;  // CPP
    exp_rst[7] = 32'h0;     // TOS
    exp_rst[8] = 32'h0;     // OPC

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_async_pc got %h want %h", pc_out, 32'h0); end
    n_checks++; if (h_out !== 32'h0) begin n_fail++; $display("FAIL reset_async_h got %h want %h", h_out, 32'h0); end
    n_checks++; if (mdr_clash !== 1'b0) begin n_fail++; $display("FAIL reset_async_clash got %b want 0", mdr_clash); end
    n_checks++; if (mar_out !== 32'h0) begin n_fail++; $display("FAIL reset_async_mar got %h want %h", mar_out, 32'h0); end
    n_checks++; if (mbr_out !== 8'h00) begin n_fail++; $display("FAIL reset_async_mbr got %h want 00", mbr_out); end
    for (int s = 0; s < 9; s++) begin
      b_sel = 4'(s);
      #1;
      n_checks++;
      if (b_bus !== exp_rst[s]) begin n_fail++; $display("FAIL reset_bsel%0d got %h want %h", s, b_bus, exp_rst[s]); end
    end
    @(negedge clk) rst = 1'b0;

    // Pending writes everywhere, then reset lands mid-cycle before the edge.
    @(negedge clk);
    c_bus = 32'hCAFE_F00D; c_wr = 9'h1FF;
    mem_mdr_ld = 1'b1; mem_mdr_d = 32'h5555_5555;
    mem_mbr_ld = 1'b1; mem_mbr_d = 8'h77;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_override_pc got %h want 0", pc_out); end
    n_checks++; if (mdr_out !== 32'h0) begin n_fail++; $display("FAIL reset_override_mdr got %h want 0", mdr_out); end
    n_checks++; if (mbr_out !== 8'h00) begin n_fail++; $display("FAIL reset_override_mbr got %h want 00", mbr_out); end
    n_checks++; if (mdr_clash !== 1'b0) begin n_fail++; $display("FAIL reset_override_clash got %b want 0", mdr_clash); end
    b_sel = 4'd4; #1;
    n_checks++; if (b_bus !== 32'h8000) begin n_fail++; $display("FAIL reset_override_sp got %h want %h", b_bus, 32'h8000); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_write_all();
    int srcs [7];
    srcs = '{0, 1, 4, 5, 6, 7, 8};
    @(negedge clk);
    c_bus = 32'hDEAD_BEEF; c_wr = 9'h1FF; b_sel = 4'd1;
    #1;
    n_checks++; if (b_bus !== 32'h0) begin n_fail++; $display("FAIL write_all_pre_pc got %h want 0", b_bus); end
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      b_sel = 4'(srcs[i]);
      #1;
      n_checks++;
      if (b_bus !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_all_bsel%0d got %h want deadbeef", srcs[i], b_bus); end
    end
    n_checks++; if (h_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_all_h got %h want deadbeef", h_out); end
    n_checks++; if (mar_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_all_mar got %h want deadbeef", mar_out); end
    n_checks++; if (mbr_out !== 8'h00) begin n_fail++; $display("FAIL write_all_mbr_untouched got %h want 00", mbr_out); end
  endtask

  task automatic test_tos_same_cycle();
    // Give TOS a distinct old value first.
    @(negedge clk);
    c_bus = 32'h0000_1111; c_wr = 9'h040;
    @(negedge clk);
    c_bus = 32'hDEAD_BEEF; c_wr = 9'h040; b_sel = 4'd7;
    #1;
    n_checks++; if (b_bus !== 32'h0000_1111) begin n_fail++; $display("FAIL tos_same_cycle_old got %h want 00001111", b_bus); end
    @(posedge clk); #1;
    n_checks++; if (b_bus !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tos_after_edge got %h want deadbeef", b_bus); end
    // Single-register write leaves the others alone.
    @(negedge clk);
    c_bus = 32'h5555_0000; c_wr = 9'h080; b_sel = 4'd8;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (b_bus !== 32'h5555_0000) begin n_fail++; $display("FAIL opc_write got %h want 55550000", b_bus); end
    b_sel = 4'd7; #1;
    n_checks++; if (b_bus !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tos_hold got %h want deadbeef", b_bus); end
    n_checks++; if (pc_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pc_hold got %h want deadbeef", pc_out); end
  endtask

  task automatic test_mbr();
    @(negedge clk);
    mem_mbr_ld = 1'b1; mem_mbr_d = 8'h9C; b_sel = 4'd3;
    #1;
    n_checks++; if (b_bus !== 32'h0) begin n_fail++; $display("FAIL mbr_pre_edge got %h want 0", b_bus); end
    @(negedge clk);
    idle_inputs();
    b_sel = 4'd2; #1;
    n_checks++; if (b_bus !== 32'hFFFF_FF9C) begin n_fail++; $display("FAIL mbr_signed got %h want ffffff9c", b_bus); end
    b_sel = 4'd3; #1;
    n_checks++; if (b_bus !== 32'h0000_009C) begin n_fail++; $display("FAIL mbr_unsigned got %h want 0000009c", b_bus); end
    n_checks++; if (mbr_out !== 8'h9C) begin n_fail++; $display("FAIL mbr_out got %h want 9c", mbr_out); end
    for (int s = 9; s < 16; s++) begin
      b_sel = 4'(s);
      #1;
      n_checks++;
      if (b_bus !== 32'h0) begin n_fail++; $display("FAIL unused_bsel%0d got %h want 0", s, b_bus); end
    end
    // Positive byte: sign extension must give zeros.
    @(negedge clk);
    mem_mbr_ld = 1'b1; mem_mbr_d = 8'h4A;
    @(negedge clk);
    idle_inputs();
    b_sel = 4'd2; #1;
    n_checks++; if (b_bus !== 32'h0000_004A) begin n_fail++; $display("FAIL mbr_signed_pos got %h want 0000004a", b_bus); end
    // A full C-bus write must not reach MBR.
    @(negedge clk);
    c_bus = 32'h0102_03FF; c_wr = 9'h1FF;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (mbr_out !== 8'h4A) begin n_fail++; $display("FAIL mbr_no_cbus got %h want 4a", mbr_out); end
  endtask

  task automatic test_mdr_clash();
    @(negedge clk);
    mem_mdr_ld = 1'b1; mem_mdr_d = 32'h1234_5678;
    c_wr = 9'h002; c_bus = 32'hAAAA_AAAA;
    #1;
    n_checks++; if (mdr_clash !== 1'b0) begin n_fail++; $display("FAIL clash_pre_edge got %b want 0", mdr_clash); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (mdr_out !== 32'h1234_5678) begin n_fail++; $display("FAIL clash_mdr got %h want 12345678", mdr_out); end
    n_checks++; if (mdr_clash !== 1'b1) begin n_fail++; $display("FAIL clash_set got %b want 1", mdr_clash); end
    @(negedge clk); #1;
    n_checks++; if (mdr_clash !== 1'b0) begin n_fail++; $display("FAIL clash_clear got %b want 0", mdr_clash); end
    // C-bus alone writes MDR with no flag.
    @(negedge clk);
    c_wr = 9'h002; c_bus = 32'hAAAA_AAAA;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (mdr_out !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL mdr_cbus got %h want aaaaaaaa", mdr_out); end
    n_checks++; if (mdr_clash !== 1'b0) begin n_fail++; $display("FAIL mdr_cbus_clash got %b want 0", mdr_clash); end
    // Memory alone writes MDR with no flag.
    @(negedge clk);
    mem_mdr_ld = 1'b1; mem_mdr_d = 32'h0BAD_F00D;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (mdr_out !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mdr_mem got %h want 0badf00d", mdr_out); end
    n_checks++; if (mdr_clash !== 1'b0) begin n_fail++; $display("FAIL mdr_mem_clash got %b want 0", mdr_clash); end
  endtask

  // Reference state, indexed by c_wr bit: MAR,MDR,PC,SP,LV,CPP,TOS,OPC,H.
  logic [31:0] m_reg [9];
  logic [7:0]  m_mbr;
  logic        m_clash;

  function automatic logic [31:0] model_b(input logic [3:0] s);
    case (s)
      4'd0: return m_reg[1];
      4'd1: return m_reg[2];
      4'd2: return {{24{m_mbr[7]}}, m_mbr};
      4'd3: return {24'h0, m_mbr};
      4'd4: return m_reg[3];
      4'd5: return m_reg[4];
      4'd6: return m_reg[5];
      4'd7: return m_reg[6];
      4'd8: return m_reg[7];
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] exp_b;
    // Start from a known state.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    idle_inputs();
    m_reg = '{32'h0, 32'h0, 32'h0, 32'h8000, 32'h8000, 32'h4000, 32'h0, 32'h0, 32'h0};
    m_mbr = 8'h00;
    m_clash = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      c_bus      = $urandom;
      c_wr       = 9'($urandom);
      b_sel      = 4'($urandom);
      mem_mdr_ld = ($urandom_range(3) == 0);
      mem_mdr_d  = $urandom;
      mem_mbr_ld = ($urandom_range(3) == 0);
      mem_mbr_d  = 8'($urandom);
      #1;
      exp_b = model_b(b_sel);
      n_checks++; if (b_bus !== exp_b) begin n_fail++; $display("FAIL rand_b cyc %0d sel %0d got %h want %h", cyc, b_sel, b_bus, exp_b); end
      n_checks++; if (h_out !== m_reg[8]) begin n_fail++; $display("FAIL rand_h cyc %0d got %h want %h", cyc, h_out, m_reg[8]); end
      n_checks++; if (mar_out !== m_reg[0]) begin n_fail++; $display("FAIL rand_mar cyc %0d got %h want %h", cyc, mar_out, m_reg[0]); end
      n_checks++; if (mdr_out !== m_reg[1]) begin n_fail++; $display("FAIL rand_mdr cyc %0d got %h want %h", cyc, mdr_out, m_reg[1]); end
      n_checks++; if (pc_out !== m_reg[2]) begin n_fail++; $display("FAIL rand_pc cyc %0d got %h want %h", cyc, pc_out, m_reg[2]); end
      n_checks++; if (mbr_out !== m_mbr) begin n_fail++; $display("FAIL rand_mbr cyc %0d got %h want %h", cyc, mbr_out, m_mbr); end
      n_checks++; if (mdr_clash !== m_clash) begin n_fail++; $display("FAIL rand_clash cyc %0d got %b want %b", cyc, mdr_clash, m_clash); end
      @(posedge clk);
      for (int r = 0; r < 9; r++)
        if (c_wr[r]) m_reg[r] = c_bus;
      if (mem_mdr_ld) m_reg[1] = mem_mdr_d;
      if (mem_mbr_ld) m_mbr = mem_mbr_d;
      m_clash = mem_mdr_ld && c_wr[1];
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    b_sel    = 4'd0;
    idle_inputs();
    test_reset();
    test_write_all();
    test_tos_same_cycle();
    test_mbr();
    test_mdr_clash();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
